// File: rtl/contador_pkg.sv
// Shared types and constants for the up/down step counter.
package contador_pkg;

    localparam int CONT_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam logic [CONT_WIDTH-1:0] CONT_MAX = {CONT_WIDTH{1'b1}};
    localparam logic [CONT_WIDTH-1:0] CONT_MIN = '0;

endpackage

// File: rtl/contador_updown_if.sv
// Bus between the sequencer controller and the step register.
interface contador_updown_if
    import contador_pkg::*;
#(
    parameter int WIDTH = CONT_WIDTH
);
    logic [WIDTH-1:0] act;
    logic             updown;
    logic [WIDTH-1:0] out;

    modport master (
        output act,
        output updown,
        input  out
    );

    modport slave (
        input  act,
        input  updown,
        output out
    );
endinterface

// File: rtl/contador_step.sv
// Combinational +1/-1 step with modulo 2^WIDTH wrap.
module contador_step
    import contador_pkg::*;
#(
    parameter int WIDTH = CONT_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    input  dir_e             dir_i,
    output logic [WIDTH-1:0] next_o
);
    logic [WIDTH:0] sum;
    logic           unused_carry;

    // Extra bit absorbs carry/borrow; truncation gives the wrap.
    always_comb begin
        sum = {1'b0, value_i};
        unique case (dir_i)
            DIR_UP:   sum = {1'b0, value_i} + (WIDTH+1)'(1);
            DIR_DOWN: sum = {1'b0, value_i} - (WIDTH+1)'(1);
            default:  sum = {1'b0, value_i};
        endcase
    end

    assign next_o       = sum[WIDTH-1:0];
    assign unused_carry = sum[WIDTH];
endmodule

// File: rtl/contador_updown.sv
// Async-reset output register around the up/down step.
module contador_updown
    import contador_pkg::*;
#(
    parameter int WIDTH = CONT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    contador_updown_if.slave  bus
);
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    contador_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value_i (bus.act),
        .dir_i   (dir_e'(bus.updown)),
        .next_o  (out_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_contador_updown.sv
// Scoreboard bench for contador_updown.
module tb_contador_updown;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cnt;
    bit   dir;
    logic [W-1:0] exp_q[$];

    contador_updown_if #(.WIDTH(W)) bus ();

    contador_updown #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_step(int a, bit up);
        int r;
        r = up ? a + 1 : a - 1;
        return ((r % M) + M) % M;
    endfunction

    task automatic check(string name, logic [W-1:0] got, logic [W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic step(int a, bit up);
        @(negedge clk);
        bus.act    = W'(a);
        bus.updown = up;
        exp_q.push_back(W'(ref_step(a, up)));
    endtask

    always @(posedge clk) begin
        #1;
        if (reset && exp_q.size() > 0) begin
            check("step", bus.out, exp_q.pop_front());
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        bus.act    = W'(7);
        bus.updown = 1'b1;
        #1;
        check("reset_async", bus.out, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.out, '0);
        end

        // Release, then feedback up count 1..15.
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(cnt, 1'b1);
            cnt = ref_step(cnt, 1'b1);
        end
        // Feedback down count 14..0.
        for (int i = 0; i < 15; i++) begin
            step(cnt, 1'b0);
            cnt = ref_step(cnt, 1'b0);
        end

        step(15, 1'b1);
        step(0, 1'b0);
        step(9, 1'b1);
        step(10, 1'b0);

        // Async reset between edges.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid", bus.out, '0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", bus.out, '0);
        @(negedge clk);
        reset = 1'b1;

        // Ping-pong sequencer.
        cnt = 0;
        dir = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (cnt == M - 1) dir = 1'b0;
            if (cnt == 0) dir = 1'b1;
            step(cnt, dir);
            cnt = ref_step(cnt, dir);
        end

        for (int i = 0; i < 40; i++) begin
            step(int'($urandom_range(0, M - 1)), bit'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
